// File: rtl/encap_packet_stream.sv
// Slices one DFX word plus its routing header into Aurora-width beats, with a
// two-entry packet buffer (active + hold), downstream backpressure and a last flag.
module encap_packet_stream #(
   parameter int DATA_WIDTH             = 1024,
   parameter int ADDR_WIDTH             = 10,
   parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2,
   parameter int NUMBER_PACKET          = 19,
   parameter int TTL_WIDTH              = 2,
   parameter int SEQ_WIDTH              = $clog2(NUMBER_PACKET),
   parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + SEQ_WIDTH + TTL_WIDTH,
   parameter int AURORA_DATA_WIDTH      = 64,
   parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH,
   parameter int CNT_WIDTH              = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
   input  logic [HEADER_WIDTH-1:0]      header_pkt_send,
   input  logic                         arbiter_gnt,
   output logic                         ready_encap_dfx,
   output logic [AURORA_DATA_WIDTH-1:0] data_in_port_0,
   output logic                         data_encap_valid,
   input  logic                         data_encap_ready,
   output logic                         data_encap_last,
   output logic [CNT_WIDTH-1:0]         pkt_sent_cnt
);

   localparam int PAD_WIDTH = NUMBER_PACKET * PAYLOAD_WIDTH;
   localparam logic [SEQ_WIDTH-1:0] LAST_IDX = SEQ_WIDTH'(NUMBER_PACKET - 1);

   generate
      if (PAD_WIDTH < DATA_DFX_WIDTH) begin : g_size_check
         $error("encap_packet_stream: NUMBER_PACKET*PAYLOAD_WIDTH must cover DATA_DFX_WIDTH");
      end
   endgenerate

   logic                              active_busy;
   logic                              hold_full;
   logic [SEQ_WIDTH-1:0]              beat_idx;

   logic [DATA_DFX_WIDTH-1:0]         hold_data_p0;
   logic [RECOGNIZE_ROUTER_WIDTH-1:0] hold_router_p0;
   logic [TTL_WIDTH-1:0]              hold_ttl_p0;

   logic [DATA_DFX_WIDTH-1:0]         act_data_p1;
   logic [RECOGNIZE_ROUTER_WIDTH-1:0] act_router_p1;
   logic [TTL_WIDTH-1:0]              act_ttl_p1;

   logic [RECOGNIZE_ROUTER_WIDTH-1:0] in_router;
   logic [TTL_WIDTH-1:0]              in_ttl;
   logic                              unused_seq;

   logic accept;
   logic last_xfer;
   logic act_free;
   logic load_from_hold;
   logic load_from_in;
   logic load_hold;

   logic [PAD_WIDTH-1:0]     act_pad;
   logic [31:0]              shamt;
   logic [PAYLOAD_WIDTH-1:0] slice;

   // The incoming seq field is regenerated per beat, so it is deliberately dropped.
   assign in_router  = header_pkt_send[HEADER_WIDTH-1 -: RECOGNIZE_ROUTER_WIDTH];
   assign in_ttl     = header_pkt_send[TTL_WIDTH-1:0];
   assign unused_seq = ^header_pkt_send[TTL_WIDTH +: SEQ_WIDTH];

   assign ready_encap_dfx = !hold_full;
   assign accept          = arbiter_gnt && !hold_full;
   assign last_xfer       = active_busy && data_encap_ready && (beat_idx == LAST_IDX);
   // Active slot can take a new packet when empty or when its final beat leaves now.
   assign act_free        = !active_busy || last_xfer;
   assign load_from_hold  = act_free && hold_full;
   assign load_from_in    = act_free && !hold_full && accept;
   assign load_hold       = !act_free && accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_busy  <= 1'b0;
         hold_full    <= 1'b0;
         beat_idx     <= '0;
         pkt_sent_cnt <= '0;
      end else begin
         if (last_xfer) begin
            pkt_sent_cnt <= pkt_sent_cnt + CNT_WIDTH'(1);
         end
         if (act_free) begin
            active_busy <= hold_full || accept;
            beat_idx    <= '0;
            hold_full   <= 1'b0;
         end else begin
            if (data_encap_ready) begin
               beat_idx <= beat_idx + SEQ_WIDTH'(1);
            end
            if (accept) begin
               hold_full <= 1'b1;
            end
         end
      end
   end

   // Stage p0: hold register, filled only while the active slot is still busy.
   always_ff @(posedge clk) begin
      if (load_hold) begin
         hold_data_p0   <= data_dfx_send;
         hold_router_p0 <= in_router;
         hold_ttl_p0    <= in_ttl;
      end
   end

   // Stage p1: active register, the packet currently being sliced onto the link.
   always_ff @(posedge clk) begin
      if (load_from_hold) begin
         act_data_p1   <= hold_data_p0;
         act_router_p1 <= hold_router_p0;
         act_ttl_p1    <= hold_ttl_p0;
      end else if (load_from_in) begin
         act_data_p1   <= data_dfx_send;
         act_router_p1 <= in_router;
         act_ttl_p1    <= in_ttl;
      end
   end

   // Zero-extending to the full beat span pads the tail of the final beat.
   assign act_pad = PAD_WIDTH'(act_data_p1);
   assign shamt   = 32'(beat_idx) * 32'(PAYLOAD_WIDTH);
   assign slice   = PAYLOAD_WIDTH'(act_pad >> shamt);

   assign data_encap_valid = active_busy;
   assign data_encap_last  = active_busy && (beat_idx == LAST_IDX);
   assign data_in_port_0   = active_busy ? {act_router_p1, beat_idx, act_ttl_p1, slice} : '0;

endmodule
